if_id_instr_buffer: RTL
=======================

// Module: if_id_instr_buffer
// PURPOSE
//  Fetch-to-decode stage of the 16-bit MIPS pipeline: a DEPTH-entry instruction queue with
//  valid/ready handshakes on both sides, synchronous flush for branches, and field split of
//  the head instruction. Its Imm4 output drives the 4-to-16 sign-extend stage; Rs/Rt/Rd drive the register file.
// PARAMETERS
//  INSTR_W  16  instruction width (format: [15:12] op, [11:8] rs, [7:4] rt, [3:0] rd/imm4)
//  PC_W     16  program counter width carried alongside each instruction
//  DEPTH    2   queue entries; power of two, >= 2
// PORTS
//  Clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous active-low reset
//  Flush      in   1        synchronous: discard all queued and same-cycle incoming instrs
//  In_Valid   in   1        fetch presents an instruction
//  In_Instr   in   INSTR_W  fetched instruction
//  In_PC      in   PC_W     address of In_Instr
//  In_Ready   out  1        queue can accept this cycle
//  Out_Valid  out  1        head entry valid
//  Out_Ready  in   1        decode consumes head this cycle
//  Out_Instr  out  INSTR_W  head instruction
//  Out_PC     out  PC_W     head PC
//  Opcode     out  4        Out_Instr[15:12]
//  Rs         out  4        Out_Instr[11:8]
//  Rt         out  4        Out_Instr[7:4]
//  Rd         out  4        Out_Instr[3:0] (R-type destination)
//  Imm4       out  4        Out_Instr[3:0] (to sign extender; identical bits to Rd)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): count=0, rd/wr pointers=0, storage cleared to 0;
//    Out_Valid=0, In_Ready=1, all data/field outputs 0. Released on next rising edge.
//  - State: count in 0..DEPTH, wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH).
//  - In_Ready = (count != DEPTH); combinational from registered count only (no Out_Ready path).
//  - push = In_Valid & In_Ready & ~Flush; pop = Out_Valid & Out_Ready & ~Flush.
//  - Out_Valid = (count != 0). Out_Instr/Out_PC = entry[rd_ptr]; fields are slices of Out_Instr.
//  - When Out_Valid=0, Out_Instr/Out_PC/fields read 0 (bubble = all-zero NOP).
//  - Latency: instr pushed at edge N is on Out_* during cycle after edge N (1 cycle) if queue was empty.
//  - Order preserved strictly FIFO; PC always travels with its instruction.
//  - Edge update: push only -> count+1; pop only -> count-1; push&pop -> count unchanged,
//    both pointers advance; neither -> hold (stall: Out_* stable while Out_Valid & ~Out_Ready).
//  - Full (count=DEPTH): In_Ready=0, In_Valid ignored; a pop that cycle frees a slot next cycle only.
//  - Empty: pop impossible (Out_Valid=0); Out_Ready ignored.
//  - Flush=1 at edge: count=0, pointers=0, no push/pop; Out_Valid=0 next cycle; In_Ready=1 next
//    cycle. Flush overrides simultaneous push and pop. Storage contents need not be cleared.
//  - Fetch side must hold In_Instr/In_PC stable while In_Valid & ~In_Ready; block does not check.
//  - Reset asserted mid-operation discards all entries immediately (async), same as power-on reset.
// TESTING
//  1 Reset: Reset_n=0 with In_Valid=1 -> Out_Valid=0, In_Ready=1, Out_Instr=0, count stays 0.
//  2 Pass-through: push 16'h3A5F @PC 16'h0004, Out_Ready=1 -> next cycle Out_Valid=1, Opcode=3,
//    Rs=A, Rt=5, Imm4=F, Out_PC=0004; popped following edge, Out_Valid=0.
//  3 Fill/stall: Out_Ready=0, push 16'h1111,16'h2222 -> In_Ready=0, head holds 1111; third push
//    16'h3333 ignored; release Out_Ready -> outputs 1111,2222 in order, 3333 never appears.
//  4 Simultaneous push+pop at count=1 for 8 cycles with PCs 0..7 -> count stays 1, outputs PCs
//    in order each cycle, pointers wrap with no loss or duplicate.
//  5 Flush with count=2 and In_Valid=1 same edge -> next cycle Out_Valid=0, In_Ready=1; next
//    push 16'h4ABC appears as head with its own PC, nothing stale.
//  6 Async reset mid-stall (count=2, Reset_n pulsed low between edges) -> Out_Valid=0 immediately.

Source files
------------

// File: rtl/if_id_instr_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction buffer.
// The fetch side and the decode side both connect through this one bundle.
interface if_id_instr_buffer_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16
);
    logic               In_Valid;
    logic [INSTR_W-1:0] In_Instr;
    logic [PC_W-1:0]    In_PC;
    logic               In_Ready;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [INSTR_W-1:0] Out_Instr;
    logic [PC_W-1:0]    Out_PC;
    logic [3:0]         Opcode;
    logic [3:0]         Rs;
    logic [3:0]         Rt;
    logic [3:0]         Rd;
    logic [3:0]         Imm4;

    // Buffer side.
    modport slave (
        input  In_Valid, In_Instr, In_PC, Out_Ready,
        output In_Ready, Out_Valid, Out_Instr, Out_PC, Opcode, Rs, Rt, Rd, Imm4
    );

    // Fetch/decode side.
    modport master (
        output In_Valid, In_Instr, In_PC, Out_Ready,
        input  In_Ready, Out_Valid, Out_Instr, Out_PC, Opcode, Rs, Rt, Rd, Imm4
    );
endinterface

// File: rtl/if_id_instr_buffer.sv
// IF/ID stage: DEPTH-entry instruction FIFO with valid/ready on both sides,
// synchronous flush, and field split of the head instruction.
module if_id_instr_buffer #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Flush,
    if_id_instr_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // In_Ready depends only on the registered count, so decode readiness
    // never reaches back into fetch combinationally.
    assign bus.In_Ready  = ~full;
    assign bus.Out_Valid = ~empty;

    assign push = bus.In_Valid & ~full & ~Flush;
    assign pop  = ~empty & bus.Out_Ready & ~Flush;

    // An empty buffer presents an all-zero NOP bubble.
    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.Out_Instr = head.instr;
    assign bus.Out_PC    = head.pc;
    assign bus.Opcode    = head.instr[15:12];
    assign bus.Rs        = head.instr[11:8];
    assign bus.Rt        = head.instr[7:4];
    assign bus.Rd        = head.instr[3:0];
    assign bus.Imm4      = head.instr[3:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: storage is cleared on reset on purpose; it is small, and
            // this keeps post-reset state fully defined.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: bus.In_Instr, pc: bus.In_PC};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
